// File: rtl/err_log_pkg.sv
// Shared definitions for the error-capture log: default widths and the
// occupancy-counter width helper used by the FIFO and the top level.
package err_log_pkg;

  localparam int DEF_DATA_W = 64;
  localparam int DEF_ADDR_W = 14;
  localparam int DEF_DEPTH  = 8;
  localparam int DEF_CNT_W  = 16;

  // Occupancy needs one bit more than the pointer so full and empty differ.
  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/err_log_fifo.sv
// Single-clock FIFO holding captured error entries. Storage is not reset;
// only pointers and occupancy are. A push into a full FIFO succeeds only
// when a pop happens on the same edge.
module err_log_fifo
  import err_log_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clr,
  input  logic                        push,
  input  logic                        pop,
  input  logic [WIDTH-1:0]            din,
  output logic [WIDTH-1:0]            dout,
  output logic                        full,
  output logic                        empty,
  output logic [level_w(DEPTH)-1:0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = level_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop & ~empty & ~clr;
  assign do_push = push & (~full | do_pop) & ~clr;
  assign dout    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^n).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level + LVL_W'(do_push) - LVL_W'(do_pop);
    end
  end

  // Entry storage, written only on an accepted push.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/err_capture_log.sv
// Readback-compare error capture: flags failing beats (data mismatch or
// external strobe), logs them into a FIFO and keeps sticky status, a
// saturating error count and the first failing address/data.
module err_capture_log
  import err_log_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cmp_valid,
  input  logic [DATA_W-1:0]          exp_data,
  input  logic [DATA_W-1:0]          rd_data,
  input  logic [ADDR_W-1:0]          rd_addr,
  input  logic                       ext_err,
  input  logic                       clr,
  output logic                       log_valid,
  input  logic                       log_ready,
  output logic [ADDR_W-1:0]          log_addr,
  output logic [DATA_W-1:0]          log_data,
  output logic [DATA_W-1:0]          log_syn,
  output logic                       error_flag,
  output logic [ADDR_W-1:0]          first_addr,
  output logic [DATA_W-1:0]          first_data,
  output logic [CNT_W-1:0]           err_count,
  output logic                       overflow,
  output logic [level_w(DEPTH)-1:0]  log_level
);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] syn;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  logic              fail_p0;
  logic [DATA_W-1:0] syn_p0;
  entry_t            wr_entry;
  entry_t            head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop_req;

  assign fail_p0  = cmp_valid & (ext_err | (exp_data != rd_data));
  assign syn_p0   = exp_data ^ rd_data;
  assign wr_entry = '{addr: rd_addr, data: rd_data, syn: syn_p0};
  assign pop_req  = ~fifo_empty & log_ready;

  err_log_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .push  (fail_p0),
    .pop   (pop_req),
    .din   (wr_entry),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (log_level)
  );

  // Head is zeroed while empty so stale storage never leaks out after reset/clr.
  assign log_valid = ~fifo_empty;
  assign log_addr  = fifo_empty ? '0 : head.addr;
  assign log_data  = fifo_empty ? '0 : head.data;
  assign log_syn   = fifo_empty ? '0 : head.syn;

  // Sticky status, saturating count and first-error capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      error_flag <= 1'b0;
      overflow   <= 1'b0;
      err_count  <= '0;
      first_addr <= '0;
      first_data <= '0;
    end else if (clr) begin
      error_flag <= 1'b0;
      overflow   <= 1'b0;
      err_count  <= '0;
      first_addr <= '0;
      first_data <= '0;
    end else if (fail_p0) begin
      error_flag <= 1'b1;
      err_count  <= sat_inc(err_count);
      if (!error_flag) begin
        first_addr <= rd_addr;
        first_data <= rd_data;
      end
      if (fifo_full && !pop_req) overflow <= 1'b1;
    end
  end

endmodule

// File: doc/err_capture_log.md
Name: err_capture_log

Overview:
- Parametrised, clocked successor to the combinational error-capture stage in the readback-compare path.
- Compares expected data against readback data per beat and also accepts an external error strobe.
- Logs each failing beat (address, readback data, XOR syndrome) into a small FIFO drained by a valid/ready handshake.
- Keeps a sticky error flag, a saturating error counter, first-error registers and an overflow indicator for the control/status side.

Parameters:
DATA_W, 64, compare/readback data width
ADDR_W, 14, readback address width
DEPTH, 8, log FIFO entries (power of two, >=2)
CNT_W, 16, error counter width

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
cmp_valid  input  1  beat valid: compare exp_data vs rd_data this cycle
exp_data  input  DATA_W  expected data
rd_data  input  DATA_W  readback data
rd_addr  input  ADDR_W  address of the beat
ext_err  input  1  external error strobe; qualifies a beat as failing even if data match (sampled only with cmp_valid)
clr  input  1  synchronous clear of flags, counter, first-error, FIFO
log_valid  output  1  FIFO non-empty, head entry presented
log_ready  input  1  consumer accepts head entry
log_addr  output  ADDR_W  head entry address
log_data  output  DATA_W  head entry readback data
log_syn  output  DATA_W  head entry syndrome (exp^rd; all-zero if ext_err only)
error_flag  output  1  sticky: any error since reset/clr
first_addr  output  ADDR_W  address of first error since reset/clr
first_data  output  DATA_W  readback data of first error
err_count  output  CNT_W  number of failing beats, saturating
overflow  output  1  sticky: an error was dropped because FIFO full
log_level  output  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (rst_n low, async): all outputs 0, FIFO empty, pointers 0; release synchronous to clk.
- fail = cmp_valid & (ext_err | (exp_data != rd_data)), evaluated combinationally in cycle N.
- On fail in cycle N:
  - entry written on edge ending N; log_valid/level visible in N+1 (1-cycle latency).
  - error_flag = 1 from N+1.
  - err_count increments, saturating at all-ones (no wrap).
- First-error: on first fail after reset/clr, first_addr/first_data captured; held until clr even when further errors occur.
- Pop: entry removed on an edge where log_valid & log_ready; head data is stable while log_valid & !log_ready.
- FIFO boundaries:
  - Full, fail, no pop: entry dropped, overflow = 1 (sticky), err_count still increments.
  - Full, fail and pop in the same cycle: both occur, level unchanged, no overflow.
  - Empty: log_ready ignored; log_addr/log_data/log_syn values don't-care.
  - Pointers wrap modulo DEPTH; level distinguishes full from empty.
- clr (synchronous, highest priority):
  - Next cycle: FIFO empty, error_flag/overflow/err_count/first_* = 0.
  - A fail or pop in the clr cycle is discarded.
- cmp_valid low: no compare, ext_err ignored, no state change except pops.
- No combinational path from inputs to outputs; all outputs registered or driven from FIFO storage/pointers.

Decomposition:
- Shared package err_log_pkg:
  - log entry struct {addr, data, syn} parametrised by widths.
  - helper constant for level width ($clog2(DEPTH)+1).
- One natural sub-module: err_log_fifo.
  - Synchronous single-clock FIFO, parameters WIDTH/DEPTH.
  - Ports: push, pop, din, dout, full, empty, level.
- Top holds compare, sticky flags, counter and first-error registers.

Test Plan:
- Reset: assert rst_n=0 mid-stream with 3 entries queued -> all outputs 0 immediately, log_valid=0 after release.
- Single mismatch: exp=64'h0, rd=64'h1, addr=14'h0010, cmp_valid=1 -> next cycle log_valid=1, log_syn=64'h1, err_count=1, first_addr=14'h0010, error_flag=1.
- ext_err only, data equal 64'hA5A5..., addr=14'h3FFF -> entry with log_syn=0, log_data=64'hA5A5..., err_count increments.
- Overflow: DEPTH=8, 10 failing beats, log_ready=0 -> level=8, overflow=1, err_count=10; drain pops the first 8 addresses in order.
- Full with simultaneous pop: FIFO full, fail and log_ready=1 same cycle -> level stays 8, overflow stays 0.
- clr priority and saturation:
  - CNT_W=4, 20 fails -> err_count=4'hF.
  - clr with a concurrent fail -> next cycle all status 0, FIFO empty, first_* 0.
